// File: rtl/prores_vlc_pkg.sv
// Shared ProRes VLC definitions: packer FSM encoding and the default codeword,
// packed-word and stream-counter widths used by the entropy encoders.
package prores_vlc_pkg;

    localparam int DEF_CODE_W = 32;
    localparam int DEF_OUT_W  = 32;
    localparam int DEF_CNT_W  = 24;

    typedef enum logic [1:0] {
        PACK  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } packer_state_e;

endpackage

// File: rtl/vlc_bit_accumulator.sv
// Left-aligned bit accumulator: masks and appends a codeword after the valid
// fill bits and pops one output word from the top, both in the same cycle.
module vlc_bit_accumulator
    import prores_vlc_pkg::*;
#(
    parameter int CODE_W = DEF_CODE_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int LEN_W  = $clog2(CODE_W + 1),
    parameter int FILL_W = $clog2(OUT_W + CODE_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [CODE_W-1:0] push_code,
    input  logic [LEN_W-1:0]  push_len,
    input  logic              pop,
    output logic [OUT_W-1:0]  top_word,
    output logic [FILL_W-1:0] fill
);
    localparam int ACC_W = OUT_W + CODE_W;
    localparam logic [FILL_W-1:0] OUT_F = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] ACC_F = FILL_W'(ACC_W);

    logic [ACC_W-1:0]  acc_q, acc_base, code_top, code_aligned;
    logic [FILL_W-1:0] fill_q, pop_amt, base, len_f;

    always_comb begin
        len_f   = push ? FILL_W'(push_len) : '0;
        pop_amt = '0;
        if (pop) begin
            pop_amt = (fill_q >= OUT_F) ? OUT_F : fill_q;
        end
        base     = fill_q - pop_amt;
        acc_base = pop ? (acc_q << OUT_W) : acc_q;
        // Shifting to the top drops code bits at and above len; a zero length
        // shifts everything out, so no separate mask is needed.
        code_top     = {{OUT_W{1'b0}}, push_code} << (ACC_F - len_f);
        code_aligned = code_top >> base;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            fill_q <= '0;
        end else begin
            acc_q  <= acc_base | code_aligned;
            fill_q <= base + len_f;
        end
    end

    assign top_word = acc_q[ACC_W-1 -: OUT_W];
    assign fill     = fill_q;

endmodule

// File: rtl/vlc_bitstream_packer.sv
// Packs variable-length codewords MSB-first into fixed-width words, with a
// zero-padding flush and a report of the unpadded stream length in bits.
module vlc_bitstream_packer
    import prores_vlc_pkg::*;
#(
    parameter int  CODE_W = DEF_CODE_W,
    parameter int  OUT_W  = DEF_OUT_W,
    parameter int  CNT_W  = DEF_CNT_W,
    localparam int LEN_W  = $clog2(CODE_W + 1)
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [CODE_W-1:0] IN_CODE,
    input  logic [LEN_W-1:0]  IN_LEN,
    input  logic              IN_FLUSH,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [OUT_W-1:0]  OUT_DATA,
    output logic              OUT_LAST,
    output logic              FLUSH_DONE,
    output logic [CNT_W-1:0]  FLUSH_BITS,
    output logic [1:0]        STATE_DBG
);
    localparam int FILL_W = $clog2(OUT_W + CODE_W + 1);
    localparam logic [FILL_W-1:0] OUT_F    = FILL_W'(OUT_W);
    localparam logic [LEN_W-1:0]  CODE_W_L = LEN_W'(CODE_W);

    packer_state_e     state_q, state_d;
    logic [FILL_W-1:0] fill;
    logic [LEN_W-1:0]  len_c;
    logic [CNT_W-1:0]  bit_cnt_q, flush_bits_q;
    logic              in_fire, out_fire;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and ready depends on registered state only.
    assign in_fire   = IN_VALID && IN_READY;
    assign out_fire  = OUT_VALID && OUT_READY;
    assign len_c     = (IN_LEN > CODE_W_L) ? CODE_W_L : IN_LEN;
    assign IN_READY  = (state_q == PACK) && (fill <= OUT_F);
    assign OUT_VALID = (fill >= OUT_F) || ((state_q == FLUSH) && (fill != '0));
    assign OUT_LAST  = (state_q == FLUSH) && OUT_VALID && (fill <= OUT_F);

    vlc_bit_accumulator #(
        .CODE_W (CODE_W),
        .OUT_W  (OUT_W),
        .LEN_W  (LEN_W),
        .FILL_W (FILL_W)
    ) u_acc (
        .clk       (CLOCK),
        .rst       (RESET),
        .push      (in_fire),
        .push_code (IN_CODE),
        .push_len  (len_c),
        .pop       (out_fire),
        .top_word  (OUT_DATA),
        .fill      (fill)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            PACK:    if (in_fire && IN_FLUSH) state_d = FLUSH;
            FLUSH:   if ((fill == '0) || (out_fire && OUT_LAST)) state_d = DONE;
            DONE:    state_d = PACK;
            default: state_d = PACK;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q      <= PACK;
            bit_cnt_q    <= '0;
            flush_bits_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DONE) begin
                bit_cnt_q <= '0;
            end else if (in_fire) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(len_c);
            end
            // No accepts happen in FLUSH, so the count is final here.
            if ((state_q == FLUSH) && (state_d == DONE)) begin
                flush_bits_q <= bit_cnt_q;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET && IN_VALID) begin
            assert (IN_LEN <= CODE_W_L);
        end
    end

    assign FLUSH_DONE = (state_q == DONE);
    assign FLUSH_BITS = flush_bits_q;
    assign STATE_DBG  = state_q;

endmodule

// File: tb/tb_vlc_bitstream_packer.sv
// Directed bench for vlc_bitstream_packer: hand-computed words go into an
// expected queue that a negedge monitor drains on every output handshake.
module tb_vlc_bitstream_packer;

    logic        clk = 1'b0;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_CODE;
    logic [5:0]  IN_LEN;
    logic        IN_FLUSH;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_DATA;
    logic        OUT_LAST;
    logic        FLUSH_DONE;
    logic [23:0] FLUSH_BITS;
    logic [1:0]  STATE_DBG;

    logic [32:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] bp_codes [6] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF,
                                  32'hCAFEF00D, 32'h0F0F0F0F, 32'hA5A5A5A5};

    vlc_bitstream_packer dut (
        .CLOCK      (clk),
        .RESET      (RESET),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_CODE    (IN_CODE),
        .IN_LEN     (IN_LEN),
        .IN_FLUSH   (IN_FLUSH),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_DATA   (OUT_DATA),
        .OUT_LAST   (OUT_LAST),
        .FLUSH_DONE (FLUSH_DONE),
        .FLUSH_BITS (FLUSH_BITS),
        .STATE_DBG  (STATE_DBG)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every output handshake must match the next expected word.
    always @(negedge clk) begin
        if (!RESET && OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_word", 64'(exp_q.size()), 64'd1);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check_eq("out_data", 64'(OUT_DATA), 64'(e[31:0]));
                check_eq("out_last", 64'(OUT_LAST), 64'(e[32]));
            end
        end
    end

    task automatic do_reset();
        RESET = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        RESET = 1'b0;
        exp_q.delete();
    endtask

    task automatic send(input logic [31:0] code, input logic [5:0] len, input logic flush);
        int n = 0;
        IN_VALID = 1'b1;
        IN_CODE  = code;
        IN_LEN   = len;
        IN_FLUSH = flush;
        while (IN_READY !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("send_ready", 64'(IN_READY), 64'd1);
        @(posedge clk);
        #1;
        IN_VALID = 1'b0;
        IN_FLUSH = 1'b0;
        IN_LEN   = '0;
        IN_CODE  = '0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_flush_done(input string tag, input logic [23:0] exp_bits);
        int n = 0;
        while (FLUSH_DONE !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_done"}, 64'(FLUSH_DONE), 64'd1);
        check_eq({tag, "_bits"}, 64'(FLUSH_BITS), 64'(exp_bits));
        @(posedge clk);
        #1;
        check_eq({tag, "_pulse"}, 64'(FLUSH_DONE), 64'd0);
        check_eq({tag, "_hold"}, 64'(FLUSH_BITS), 64'(exp_bits));
        check_eq({tag, "_ready"}, 64'(IN_READY), 64'd1);
        check_eq({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        IN_VALID  = 1'b0;
        IN_CODE   = '0;
        IN_LEN    = '0;
        IN_FLUSH  = 1'b0;
        OUT_READY = 1'b1;

        do_reset();
        check_eq("rst_out_valid", 64'(OUT_VALID), 64'd0);
        check_eq("rst_out_last", 64'(OUT_LAST), 64'd0);
        check_eq("rst_flush_done", 64'(FLUSH_DONE), 64'd0);
        check_eq("rst_flush_bits", 64'(FLUSH_BITS), 64'd0);
        check_eq("rst_in_ready", 64'(IN_READY), 64'd1);
        check_eq("rst_state", 64'(STATE_DBG), 64'd0);

        // Eight nibbles make one full word; it appears the cycle after the 8th accept.
        exp_q.push_back({1'b0, 32'h12345678});
        for (int i = 1; i <= 8; i++) begin
            send(32'(i), 6'd4, 1'b0);
            if (i == 7) check_eq("latency_not_yet", 64'(OUT_VALID), 64'd0);
        end
        check_eq("latency_valid", 64'(OUT_VALID), 64'd1);
        wait_drain("nibbles_drain");
        // Empty-fill flush of a 32-bit stream: no word, count still reported.
        send(32'h0, 6'd0, 1'b1);
        wait_flush_done("flush_empty32", 24'd32);

        // Masking of high code bits and a len-0 code mid-stream.
        exp_q.push_back({1'b1, 32'hE0000000});
        send(32'h000000FF, 6'd3, 1'b0);
        send(32'hFFFFFFFF, 6'd0, 1'b0);
        send(32'h0, 6'd0, 1'b1);
        wait_flush_done("flush_ff3", 24'd3);

        // Flush carried by the code itself; FLUSH_DONE one cycle after the last handshake.
        exp_q.push_back({1'b1, 32'hB0000000});
        send(32'h16, 6'd5, 1'b1);
        check_eq("last_valid", 64'(OUT_VALID), 64'd1);
        check_eq("last_flag", 64'(OUT_LAST), 64'd1);
        check_eq("flush_in_ready", 64'(IN_READY), 64'd0);
        @(posedge clk);
        #1;
        check_eq("b0_done", 64'(FLUSH_DONE), 64'd1);
        check_eq("b0_bits", 64'(FLUSH_BITS), 64'd5);
        @(posedge clk);
        #1;
        check_eq("b0_pulse", 64'(FLUSH_DONE), 64'd0);
        check_eq("b0_hold", 64'(FLUSH_BITS), 64'd5);

        // Codes straddling a word boundary; flush leaves 4 bits for a padded last word.
        exp_q.push_back({1'b0, 32'hABC12345});
        exp_q.push_back({1'b1, 32'h60000000});
        send(32'hFFFFFABC, 6'd12, 1'b0);
        send(32'h00000123, 6'd12, 1'b0);
        send(32'h00000456, 6'd12, 1'b1);
        wait_flush_done("flush_36", 24'd36);

        // Backpressure with full-width codes: IN_READY drops once fill exceeds a word.
        OUT_READY = 1'b0;
        foreach (bp_codes[i]) exp_q.push_back({1'b0, bp_codes[i]});
        fork
            begin
                foreach (bp_codes[i]) send(bp_codes[i], 6'd32, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                check_eq("stall_valid", 64'(OUT_VALID), 64'd1);
                check_eq("stall_data_a", 64'(OUT_DATA), 64'(bp_codes[0]));
                repeat (7) @(posedge clk);
                #1;
                check_eq("stall_in_ready", 64'(IN_READY), 64'd0);
                check_eq("stall_data_b", 64'(OUT_DATA), 64'(bp_codes[0]));
                check_eq("stall_last", 64'(OUT_LAST), 64'd0);
                OUT_READY = 1'b1;
            end
        join
        wait_drain("bp_drain");
        send(32'h0, 6'd0, 1'b1);
        wait_flush_done("flush_bp", 24'd192);

        // Reset with 20 bits pending discards them entirely.
        send(32'h000FFFFF, 6'd20, 1'b0);
        check_eq("pre_rst_valid", 64'(OUT_VALID), 64'd0);
        RESET = 1'b1;
        @(posedge clk);
        #1;
        RESET = 1'b0;
        check_eq("mid_rst_valid", 64'(OUT_VALID), 64'd0);
        check_eq("mid_rst_ready", 64'(IN_READY), 64'd1);
        check_eq("mid_rst_last", 64'(OUT_LAST), 64'd0);
        exp_q.push_back({1'b0, 32'hABCDEF01});
        for (int i = 0; i < 8; i++) send(32'((i + 10) % 16), 6'd4, 1'b0);
        wait_drain("post_rst_drain");
        send(32'h0, 6'd0, 1'b1);
        wait_flush_done("flush_post_rst", 24'd32);

        // Len-0 flush on an empty stream with garbage code bits.
        send(32'hFFFFFFFF, 6'd0, 1'b1);
        check_eq("empty_valid", 64'(OUT_VALID), 64'd0);
        wait_flush_done("flush_len0", 24'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
